// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf : instruction-fetch stage with a DEPTH-entry prefetch queue.
//
// Keeps at most one instruction-memory read outstanding, buffers returned
// words together with their PCs in a circular queue, and hands one
// instruction per cycle to the IF/ID register. Handles decode stalls,
// branch redirects (flush plus discard of an in-flight response), HALT
// detection (all-zero word) and a sticky fetch error.
//
// Optional feature macro: FETCH_BUF_BYPASS_EN
//   defined     - a response arriving while the queue is empty (no stall,
//                 no drop, no redirect) is written straight into IF/ID.
//   not defined - every response passes through the queue.
//
// Parameters:
//   WIDTH    instruction and PC width
//   DEPTH    prefetch queue entries (power of 2, >= 2)
//   PC_STEP  sequential PC increment
//   RESET_PC fetch PC after reset
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               decode stall, IF/ID holds
//   redirect/_pc        taken branch: flush and refetch from redirect_pc
//   imem_rd/imem_addr   read request and address to instruction memory
//   imem_done/_data/_err read completion, returned word, error flag
//   instr/PC/PC2_IFID   IF/ID instruction, its PC and PC + PC_STEP
//   valid_IFID          IF/ID holds a real fetched instruction
//   halt_IFID           IF/ID holds a valid HALT (all-zero) instruction
//   mStallInstr         nothing can be delivered to decode this cycle
//   err                 sticky fetch error, cleared only by rst
// -----------------------------------------------------------------------------
module fetch_buf #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter int               PC_STEP  = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_rd,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_done,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             imem_err,
    output logic [WIDTH-1:0] instr_IFID,
    output logic [WIDTH-1:0] PC_IFID,
    output logic [WIDTH-1:0] PC2_IFID,
    output logic             valid_IFID,
    output logic             halt_IFID,
    output logic             mStallInstr,
    output logic             err
);

    localparam int               PW      = $clog2(DEPTH);
    localparam int               CW      = PW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [WIDTH-1:0] STEP_C  = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] NOP_C   = WIDTH'(16'h0800);

    // Fetch control state
    logic [WIDTH-1:0] fpc_q, fpc_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             inflight_q, inflight_d;
    logic             drop_q, drop_d;
    logic             halt_seen_q, halt_seen_d;
    logic             err_q, err_d;

    // Queue state
    logic [WIDTH-1:0] q_instr_q [DEPTH];
    logic [WIDTH-1:0] q_pc_q    [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // IF/ID register
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc2_q, pc2_d;
    logic             valid_q, valid_d;
    logic             halt_q, halt_d;

    // Per-cycle events
    logic             resp_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             issue_s;
    logic             bypass_hit_s;
    logic             q_empty_s;
    logic [WIDTH-1:0] fpc_inc_s;
    logic             fpc_carry_s;

    assign q_empty_s = (count_q == '0);

    // A done only counts while a request is outstanding; late dones after
    // reset or before any request are ignored.
    assign resp_s   = imem_done & inflight_q;
    // Word is kept (queued or bypassed) unless it is stale or being flushed.
    assign accept_s = resp_s & ~drop_q & ~redirect;
    assign issue_s  = ~inflight_q & (count_q < DEPTH_C) & ~halt_seen_q & ~rst;
    assign pop_s    = ~redirect & ~stall & ~q_empty_s;

    assign {fpc_carry_s, fpc_inc_s} = {1'b0, fpc_q} + {1'b0, STEP_C};

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass_hit_s = resp_s & q_empty_s & ~stall & ~drop_q & ~redirect;
`else
    assign bypass_hit_s = 1'b0;
`endif

    assign push_s = accept_s & ~bypass_hit_s;

    // Next-state logic for fetch control, queue pointers and IF/ID
    always_comb begin
        fpc_d       = fpc_q;
        addr_d      = addr_q;
        inflight_d  = inflight_q;
        drop_d      = drop_q;
        halt_seen_d = halt_seen_q;
        err_d       = err_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        pc2_d       = pc2_q;
        valid_d     = valid_q;

        // fetch PC: redirect wins, otherwise advance on every kept word
        if (redirect) begin
            fpc_d = redirect_pc;
        end else if (accept_s) begin
            fpc_d = fpc_inc_s;
        end else begin
            fpc_d = fpc_q;
        end

        // request tracking; issue and response are exclusive via inflight_q
        if (issue_s) begin
            inflight_d = 1'b1;
            addr_d     = fpc_d;
        end else if (resp_s) begin
            inflight_d = 1'b0;
        end else begin
            inflight_d = inflight_q;
        end

        // an outstanding request that survives a redirect must be discarded
        if (redirect) begin
            drop_d = inflight_q & ~imem_done;
        end else if (resp_s) begin
            drop_d = 1'b0;
        end else begin
            drop_d = drop_q;
        end

        if (redirect) begin
            halt_seen_d = 1'b0;
        end else if (accept_s && (imem_data == '0)) begin
            halt_seen_d = 1'b1;
        end else begin
            halt_seen_d = halt_seen_q;
        end

        err_d = err_q | (resp_s & imem_err) | (accept_s & fpc_carry_s);

        // queue bookkeeping
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
            wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // IF/ID register
        if (redirect) begin
            instr_d = NOP_C;
            valid_d = 1'b0;
        end else if (bypass_hit_s) begin
            instr_d = imem_data;
            pc_d    = fpc_q;
            pc2_d   = fpc_inc_s;
            valid_d = 1'b1;
        end else if (!stall) begin
            if (!q_empty_s) begin
                instr_d = q_instr_q[rd_ptr_q];
                pc_d    = q_pc_q[rd_ptr_q];
                pc2_d   = q_pc_q[rd_ptr_q] + STEP_C;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_C;
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end

        halt_d = valid_d & (instr_d == '0);
    end

    // Control and IF/ID state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q       <= RESET_PC;
            addr_q      <= RESET_PC;
            inflight_q  <= 1'b0;
            drop_q      <= 1'b0;
            halt_seen_q <= 1'b0;
            err_q       <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            instr_q     <= NOP_C;
            pc_q        <= '0;
            pc2_q       <= STEP_C;
            valid_q     <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            fpc_q       <= fpc_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            halt_seen_q <= halt_seen_d;
            err_q       <= err_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pc2_q       <= pc2_d;
            valid_q     <= valid_d;
            halt_q      <= halt_d;
        end
    end

    // Queue storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_instr_q[wr_ptr_q] <= imem_data;
            q_pc_q[wr_ptr_q]    <= fpc_q;
        end
    end

    assign imem_rd     = inflight_q;
    assign imem_addr   = addr_q;
    assign instr_IFID  = instr_q;
    assign PC_IFID     = pc_q;
    assign PC2_IFID    = pc2_q;
    assign valid_IFID  = valid_q;
    assign halt_IFID   = halt_q;
    assign err         = err_q;
    assign mStallInstr = q_empty_s & ~bypass_hit_s;

endmodule

// File: tb/tb_fetch_buf.sv
// -----------------------------------------------------------------------------
// tb_fetch_buf : directed self-checking bench for fetch_buf (default params).
// Memory model answers in the cycle the request is visible; word at address
// a is 16'h4000 + a, except halt_addr which returns 16'h0000.
// -----------------------------------------------------------------------------
module tb_fetch_buf;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        imem_err;
    logic [15:0] instr_IFID;
    logic [15:0] PC_IFID;
    logic [15:0] PC2_IFID;
    logic        valid_IFID;
    logic        halt_IFID;
    logic        mStallInstr;
    logic        err;

    int          n_checks;
    int          n_errors;
    int          n_push;
    logic        mem_en;
    logic        err_inj;
    logic [15:0] halt_addr;

    fetch_buf #(
        .WIDTH   (16),
        .DEPTH   (4),
        .PC_STEP (2),
        .RESET_PC(16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_done  (imem_done),
        .imem_data  (imem_data),
        .imem_err   (imem_err),
        .instr_IFID (instr_IFID),
        .PC_IFID    (PC_IFID),
        .PC2_IFID   (PC2_IFID),
        .valid_IFID (valid_IFID),
        .halt_IFID  (halt_IFID),
        .mStallInstr(mStallInstr),
        .err        (err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rom(input logic [15:0] a);
        if (a == halt_addr) return 16'h0000;
        return 16'h4000 + a;
    endfunction

    task automatic mem_drive();
        if (mem_en) begin
            imem_done = imem_rd;
            imem_data = rom(imem_addr);
            imem_err  = err_inj & imem_rd;
        end
    endtask

    task automatic step();
        if (imem_done && imem_rd) n_push++;
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (valid_IFID) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rd(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (imem_rd) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed test sequence
    initial begin
        bit found_halt;
        bit seen_rd10;
        bit got_done;
        clk = 1'b0; rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0000; imem_done = 1'b0; imem_data = 16'h0000;
        imem_err = 1'b0; n_checks = 0; n_errors = 0; n_push = 0;
        mem_en = 1'b1; err_inj = 1'b0; halt_addr = 16'hFFF0;

        // ---- reset values
        repeat (3) step();
        check_eq("rst_rd",    {31'd0, imem_rd},    32'd0);
        check_eq("rst_addr",  {16'd0, imem_addr},  32'h0000);
        check_eq("rst_instr", {16'd0, instr_IFID}, 32'h0800);
        check_eq("rst_pc",    {16'd0, PC_IFID},    32'h0000);
        check_eq("rst_pc2",   {16'd0, PC2_IFID},   32'h0002);
        check_eq("rst_valid", {31'd0, valid_IFID}, 32'd0);
        check_eq("rst_halt",  {31'd0, halt_IFID},  32'd0);
        check_eq("rst_err",   {31'd0, err},        32'd0);
        check_eq("rst_mstall",{31'd0, mStallInstr},32'd1);

        // ---- first fetch after reset release
        rst = 1'b0;
        check_eq("rd_before_edge", {31'd0, imem_rd}, 32'd0);
        step();
        check_eq("rd_first",   {31'd0, imem_rd},   32'd1);
        check_eq("addr_first", {16'd0, imem_addr}, 32'h0000);
        step();
`ifdef FETCH_BUF_BYPASS_EN
        check_eq("byp_instr", {16'd0, instr_IFID}, 32'h4000);
        check_eq("byp_valid", {31'd0, valid_IFID}, 32'd1);
`else
        check_eq("lat_valid_e1", {31'd0, valid_IFID}, 32'd0);
        check_eq("lat_mstall_e1", {31'd0, mStallInstr}, 32'd0);
        step();
`endif
        check_eq("first_instr", {16'd0, instr_IFID}, 32'h4000);
        check_eq("first_pc",    {16'd0, PC_IFID},    32'h0000);
        check_eq("first_pc2",   {16'd0, PC2_IFID},   32'h0002);
        check_eq("first_valid", {31'd0, valid_IFID}, 32'd1);

        // ---- stall: queue fills to DEPTH, IF/ID holds
        stall = 1'b1;
        n_push = 0;
        repeat (14) step();
        check_eq("stall_pushes", n_push,              32'd4);
        check_eq("stall_rd_full",{31'd0, imem_rd},    32'd0);
        check_eq("stall_mstall", {31'd0, mStallInstr},32'd0);
        check_eq("stall_instr",  {16'd0, instr_IFID}, 32'h4000);
        check_eq("stall_pc",     {16'd0, PC_IFID},    32'h0000);
        check_eq("stall_valid",  {31'd0, valid_IFID}, 32'd1);

        // ---- release: queued words on consecutive cycles, in order
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("drain_instr", {16'd0, instr_IFID}, 32'h4002 + 32'(2 * k));
            check_eq("drain_pc",    {16'd0, PC_IFID},    32'h0002 + 32'(2 * k));
            check_eq("drain_pc2",   {16'd0, PC2_IFID},   32'h0004 + 32'(2 * k));
            check_eq("drain_valid", {31'd0, valid_IFID}, 32'd1);
        end

        // ---- redirect while a request is in flight
        mem_en = 1'b0; imem_done = 1'b0; imem_err = 1'b0;
        wait_rd("redir_inflight_rd", 20);
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        check_eq("redir_valid", {31'd0, valid_IFID}, 32'd0);
        check_eq("redir_instr", {16'd0, instr_IFID}, 32'h0800);
        check_eq("redir_old_rd",{31'd0, imem_rd},    32'd1);
        imem_done = 1'b1; imem_data = 16'hBAD0;
        step();
        imem_done = 1'b0;
        check_eq("redir_drop_rd", {31'd0, imem_rd}, 32'd0);
        step();
        check_eq("redir_new_addr", {16'd0, imem_addr}, 32'h0100);
        mem_en = 1'b1;
        mem_drive();
        wait_valid("redir_wait", 20);
        check_eq("redir_pc",    {16'd0, PC_IFID},    32'h0100);
        check_eq("redir_instr2",{16'd0, instr_IFID}, 32'h4100);

        // ---- redirect coinciding with imem_done
        mem_en = 1'b0; imem_done = 1'b0;
        wait_rd("coin_rd", 20);
        imem_done = 1'b1; imem_data = 16'h1234;
        redirect = 1'b1; redirect_pc = 16'h0200;
        step();
        redirect = 1'b0; imem_done = 1'b0;
        check_eq("coin_instr", {16'd0, instr_IFID}, 32'h0800);
        check_eq("coin_valid", {31'd0, valid_IFID}, 32'd0);
        mem_en = 1'b1;
        mem_drive();
        wait_valid("coin_wait", 20);
        check_eq("coin_pc",    {16'd0, PC_IFID},    32'h0200);
        check_eq("coin_instr2",{16'd0, instr_IFID}, 32'h4200);

        // ---- HALT at PC 8: flagged in IF/ID, no fetch of PC 10
        halt_addr = 16'h0008;
        redirect = 1'b1; redirect_pc = 16'h0000;
        step();
        redirect = 1'b0;
        found_halt = 1'b0; seen_rd10 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (imem_rd && imem_addr == 16'h000A) seen_rd10 = 1'b1;
            if (valid_IFID) begin
                check_eq("halt_flag", {31'd0, halt_IFID}, {31'd0, PC_IFID == 16'h0008});
                if (PC_IFID == 16'h0008) begin
                    found_halt = 1'b1;
                    check_eq("halt_instr", {16'd0, instr_IFID}, 32'h0000);
                end
            end
        end
        check_eq("halt_seen_in_ifid", {31'd0, found_halt}, 32'd1);
        check_eq("halt_no_fetch10",   {31'd0, seen_rd10},  32'd0);
        check_eq("halt_rd_idle",      {31'd0, imem_rd},    32'd0);

        // ---- redirect resumes fetch; imem_err makes err sticky
        redirect = 1'b1; redirect_pc = 16'h0020;
        step();
        redirect = 1'b0;
        wait_valid("resume_wait", 20);
        check_eq("resume_pc", {16'd0, PC_IFID}, 32'h0020);
        check_eq("err_pre",   {31'd0, err},     32'd0);
        err_inj = 1'b1;
        got_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_done) begin
                got_done = 1'b1;
                break;
            end
        end
        if (!got_done) check_eq("err_done_timeout", 32'd0, 32'd1);
        err_inj = 1'b0;
        step();
        check_eq("err_set", {31'd0, err}, 32'd1);
        repeat (5) step();
        check_eq("err_hold", {31'd0, err}, 32'd1);
        redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        check_eq("err_hold_redir", {31'd0, err}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("err_cleared", {31'd0, err}, 32'd0);

        // ---- fetch PC wrap raises err
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        wait_valid("wrap_wait", 20);
        check_eq("wrap_pc",    {16'd0, PC_IFID},    32'hFFFE);
        check_eq("wrap_pc2",   {16'd0, PC2_IFID},   32'h0000);
        check_eq("wrap_instr", {16'd0, instr_IFID}, 32'h3FFE);
        check_eq("wrap_err",   {31'd0, err},        32'd1);
        wait_valid("wrap_next", 20);
        check_eq("wrap_next_pc", {16'd0, PC_IFID}, 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
